// File: rtl/cheri_tsmap_arbiter.sv
// Single-port TSMAP SRAM arbiter: fixed-latency revocation-check reads, bus set/clear
// access, and a background bulk-clear engine with anti-starvation against the bus.
module cheri_tsmap_arbiter #(
    parameter int unsigned TSMapSize   = 1024,
    parameter int unsigned StarveLimit = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        trvk_cs_i,
    input  logic [15:0] trvk_addr_i,
    output logic [31:0] trvk_rdata_o,
    input  logic        bus_req_i,
    input  logic        bus_we_i,
    input  logic [15:0] bus_addr_i,
    input  logic [31:0] bus_wdata_i,
    input  logic [3:0]  bus_be_i,
    output logic        bus_gnt_o,
    output logic        bus_rvalid_o,
    output logic [31:0] bus_rdata_o,
    output logic        bus_err_o,
    input  logic        clr_start_i,
    input  logic [15:0] clr_base_i,
    input  logic [15:0] clr_count_i,
    output logic        clr_busy_o,
    output logic        clr_done_o,
    output logic        mem_cs_o,
    output logic        mem_we_o,
    output logic [15:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_be_o,
    input  logic [31:0] mem_rdata_i
);
    localparam logic [16:0] MapEnd = 17'(TSMapSize);
    localparam int unsigned SW = $clog2(StarveLimit + 1);
    localparam logic [SW-1:0] StarveMax = SW'(StarveLimit);

    typedef enum logic [1:0] {ClrIdle, ClrRun, ClrDone} clr_state_e;
    typedef enum logic [1:0] {OwnNone, OwnTrvk, OwnBus} owner_e;

    clr_state_e    state_q;
    owner_e        owner_q, owner_d;
    logic [15:0]   ptr_q, remain_q;
    logic [SW-1:0] starve_q;
    logic          rvalid_q, err_q;

    logic trvk_hit, bus_in_range, clr_in_range, clr_want, clr_forced, bus_gnt, clr_win;

    assign trvk_hit     = trvk_cs_i & ({1'b0, trvk_addr_i} < MapEnd);
    assign bus_in_range = {1'b0, bus_addr_i} < MapEnd;
    assign clr_in_range = {1'b0, ptr_q} < MapEnd;
    assign clr_want     = (state_q == ClrRun) & clr_in_range;
    assign clr_forced   = clr_want & (starve_q == StarveMax);
    // Any check-stage request blocks the others, even out of range, so the bus sees a simple rule.
    assign bus_gnt      = bus_req_i & ~trvk_cs_i & ~clr_forced;
    assign clr_win      = clr_want & ~trvk_cs_i & ~bus_gnt;

    always_comb begin
        mem_cs_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_be_o    = '0;
        if (trvk_hit) begin
            mem_cs_o   = 1'b1;
            mem_addr_o = trvk_addr_i;
        end else if (bus_gnt && bus_in_range) begin
            mem_cs_o    = 1'b1;
            mem_we_o    = bus_we_i;
            mem_addr_o  = bus_addr_i;
            mem_wdata_o = bus_we_i ? bus_wdata_i : '0;
            mem_be_o    = bus_we_i ? bus_be_i : '0;
        end else if (clr_win) begin
            mem_cs_o   = 1'b1;
            mem_we_o   = 1'b1;
            mem_addr_o = ptr_q;
            mem_be_o   = 4'hF;
        end
    end

    always_comb begin
        owner_d = OwnNone;
        if (trvk_hit)                                  owner_d = OwnTrvk;
        else if (bus_gnt && !bus_we_i && bus_in_range) owner_d = OwnBus;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            owner_q  <= OwnNone;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            owner_q  <= owner_d;
            rvalid_q <= bus_gnt;
            err_q    <= bus_gnt & ~bus_in_range;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ClrIdle;
            ptr_q    <= '0;
            remain_q <= '0;
            starve_q <= '0;
        end else begin
            case (state_q)
                ClrIdle: begin
                    starve_q <= '0;
                    if (clr_start_i) begin
                        ptr_q    <= clr_base_i;
                        remain_q <= clr_count_i;
                        state_q  <= (clr_count_i == 16'd0) ? ClrDone : ClrRun;
                    end
                end
                ClrRun: begin
                    // Words past the end of the map are skipped rather than wrapped.
                    if (!clr_in_range) begin
                        state_q  <= ClrDone;
                        starve_q <= '0;
                    end else if (clr_win) begin
                        ptr_q    <= ptr_q + 16'd1;
                        remain_q <= remain_q - 16'd1;
                        starve_q <= '0;
                        if (remain_q == 16'd1) state_q <= ClrDone;
                    end else if (bus_gnt && starve_q != StarveMax) begin
                        starve_q <= starve_q + 1'b1;
                    end
                end
                ClrDone: state_q <= ClrIdle;
                default: state_q <= ClrIdle;
            endcase
        end
    end

    assign bus_gnt_o    = bus_gnt;
    assign bus_rvalid_o = rvalid_q;
    assign bus_err_o    = err_q;
    assign bus_rdata_o  = (owner_q == OwnBus)  ? mem_rdata_i : '0;
    assign trvk_rdata_o = (owner_q == OwnTrvk) ? mem_rdata_i : '0;
    assign clr_busy_o   = (state_q != ClrIdle);
    assign clr_done_o   = (state_q == ClrDone);
endmodule

// File: doc/cheri_tsmap_arbiter.md
# cheri_tsmap_arbiter

Owns the single-port TSMAP (revocation bitmap) SRAM and shares it between three requesters: the revocation-check pipeline read port (fixed latency, never stalled), a software bus port for the allocator to set and clear revocation bits, and a background bulk-clear engine that zeroes a word range. It sits between the revocation-check stage, the TSMAP bus slave and the SRAM macro, and guarantees the check stage always sees read data exactly one cycle after its chip-select.

## Interface
- TSMapSize, 1024: number of 32-bit TSMAP words; valid word addresses are 0..TSMapSize-1.
- StarveLimit, 16: consecutive cycles the clear engine may lose to the bus before it is forced a slot.

- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- trvk_cs_i  in  1  check-stage read request.
- trvk_addr_i  in  16  check-stage word address.
- trvk_rdata_o  out  32  check-stage read data, valid the cycle after trvk_cs_i.
- bus_req_i  in  1  bus request.
- bus_we_i  in  1  bus write (1) / read (0).
- bus_addr_i  in  16  bus word address.
- bus_wdata_i  in  32  bus write data.
- bus_be_i  in  4  bus byte enables.
- bus_gnt_o  out  1  bus grant, combinational, same cycle as accepted request.
- bus_rvalid_o  out  1  response valid, one cycle after grant (reads and writes).
- bus_rdata_o  out  32  read data, qualified by bus_rvalid_o.
- bus_err_o  out  1  out-of-range error, qualified by bus_rvalid_o.
- clr_start_i  in  1  start bulk clear (pulse).
- clr_base_i  in  16  first word to clear.
- clr_count_i  in  16  number of words to clear.
- clr_busy_o  out  1  clear engine active.
- clr_done_o  out  1  one-cycle completion pulse.
- mem_cs_o  out  1  SRAM chip select.
- mem_we_o  out  1  SRAM write enable.
- mem_addr_o  out  16  SRAM word address.
- mem_wdata_o  out  32  SRAM write data.
- mem_be_o  out  4  SRAM byte enables.
- mem_rdata_i  in  32  SRAM read data, one cycle after a read cs.

## Operation
- Fixed priority per cycle: trvk > bus > clear, except when starve counter == StarveLimit: clear wins over bus (trvk still wins).
- trvk: in-range -> SRAM read; out-of-range (addr >= TSMapSize) -> no SRAM access, trvk_rdata_o = 0 next cycle. Never stalled.
- bus: gnt = req & ~trvk_cs & ~clear_forced. In-range write -> SRAM write with bus_be_i; in-range read -> SRAM read. Out-of-range -> gnt asserted, no SRAM access, rvalid with err=1, rdata=0.
- Read-data routing: registered owner tag (NONE/TRVK/BUS) from previous cycle; trvk_rdata_o = mem_rdata_i if owner TRVK else 0; bus_rdata_o = mem_rdata_i if owner BUS else 0.
- Clear FSM: IDLE -> (clr_start_i) latch ptr=clr_base_i, remain=clr_count_i -> RUN; if clr_count_i==0 go directly to DONE. RUN: when slot won, write 32'h0 (be=4'hF) at ptr, ptr+1, remain-1; after last write, or when ptr >= TSMapSize (remaining words skipped, no access) -> DONE. DONE: clr_done_o=1 one cycle -> IDLE.
- clr_start_i while busy or in DONE: ignored.
- Starve counter: increments each RUN cycle clear loses to bus, saturates at StarveLimit, clears when clear wins a slot or leaves RUN. Cycles lost to trvk do not increment.
- Ptr/remain arithmetic 16-bit; ptr compare against TSMapSize prevents wrap.

## Timing
- Reset values: all outputs 0; FSM IDLE; owner NONE; starve counter 0.
- mem_* combinational from current-cycle requests; bus_gnt_o combinational.
- Latency: trvk/bus data 1 cycle after cs/gnt; back-to-back grants allowed every cycle.
- clr_busy_o = 1 in RUN and DONE. Clear of N in-range words with no contention: start cycle T, writes T+1..T+N, clr_done_o at T+N+1.
- Same-cycle trvk+bus+clear: trvk issued, bus gnt=0 (retries), clear stalled.
- Reset mid-clear: aborts immediately, no clr_done_o, partially cleared words stay cleared.
- Ordering: SRAM accesses in grant order; read after write in a later cycle returns new data.

## Test plan
- trvk_cs_i at addr 5 (mem word 5 = 32'hA5A5_0001) -> next cycle trvk_rdata_o = 32'hA5A5_0001; addr 1024 -> no mem_cs_o, rdata 0.
- Bus write addr 3, wdata 32'h1234_5678, be 4'b0011, then read 3 -> gnt both, rvalid each next cycle, read shows only low 16 bits updated, err=0.
- trvk_cs_i and bus_req_i held together 3 cycles -> bus_gnt_o=0 those cycles, granted cycle after trvk drops.
- Clear base 10 count 4, idle bus -> writes 10..13 on 4 consecutive cycles, clr_done_o pulse at start+5; count 0 -> done at start+1, no writes.
- Clear running, bus_req_i held continuously -> after 16 bus grants, one cycle gnt=0 with clear write, counter reset.
- Clear base 1020 count 10 with TSMapSize 1024 -> writes 1020..1023 only, then done; reset asserted mid-clear -> all outputs 0, no done pulse.
